// File: rtl/branch_cmp_pipe_pkg.sv
// Shared branch-compare op encodings, used by the decoder and by the compare pipeline.
package branch_cmp_pipe_pkg;

  localparam logic [2:0] CMP_EQ  = 3'd0;
  localparam logic [2:0] CMP_NE  = 3'd1;
  localparam logic [2:0] CMP_LTZ = 3'd2;
  localparam logic [2:0] CMP_GEZ = 3'd3;
  localparam logic [2:0] CMP_LEZ = 3'd4;
  localparam logic [2:0] CMP_GTZ = 3'd5;
  localparam logic [2:0] CMP_LT  = 3'd6;
  localparam logic [2:0] CMP_LTU = 3'd7;

endpackage

// File: rtl/branch_cmp_pipe_core.sv
// Purely combinational branch condition evaluator (module branch_cmp_core).
module branch_cmp_core
  import branch_cmp_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             taken,
  output logic             eq
);

  logic w_neg;
  logic w_zero;
  logic w_lt_s;
  logic w_lt_u;

  // Zero-compare modes look only at a; b is ignored.
  assign eq     = (a == b);
  assign w_neg  = a[WIDTH-1];
  assign w_zero = (a == '0);
  assign w_lt_s = ($signed(a) < $signed(b));
  assign w_lt_u = (a < b);

  always_comb begin
    taken = 1'b0;
    case (op)
      CMP_EQ:  taken = eq;
      CMP_NE:  taken = ~eq;
      CMP_LTZ: taken = w_neg;
      CMP_GEZ: taken = ~w_neg;
      CMP_LEZ: taken = w_neg | w_zero;
      CMP_GTZ: taken = ~w_neg & ~w_zero;
      CMP_LT:  taken = w_lt_s;
      CMP_LTU: taken = w_lt_u;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cmp_pipe.sv
// Branch compare with a STAGES-deep valid/ready result pipeline, flush and async reset.
module branch_cmp_pipe
  import branch_cmp_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic             eq
);

  logic              w_taken;
  logic              w_eq;
  logic              w_xfer;
  logic [STAGES:1]   w_adv;

  logic r_valid [1:STAGES];
  logic r_taken [1:STAGES];
  logic r_eq    [1:STAGES];

  branch_cmp_core #(.WIDTH(WIDTH)) u_core (
    .a     (a),
    .b     (b),
    .op    (op),
    .taken (w_taken),
    .eq    (w_eq)
  );

  // Stage k advances when out_ready is high or any stage from k to the end is empty.
  always_comb begin : adv_chain
    logic acc;
    w_adv = '0;
    acc   = out_ready;
    for (int k = STAGES; k >= 1; k--) begin
      acc      = acc | ~r_valid[k];
      w_adv[k] = acc;
    end
  end

  assign in_ready = resetn & ~flush & w_adv[1];
  assign w_xfer   = in_valid & in_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 1; k <= STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_taken[k] <= 1'b0;
        r_eq[k]    <= 1'b0;
      end
    end else if (flush) begin
      for (int k = 1; k <= STAGES; k++) begin
        r_valid[k] <= 1'b0;
      end
    end else begin
      if (w_adv[1]) begin
        r_valid[1] <= w_xfer;
        r_taken[1] <= w_taken;
        r_eq[1]    <= w_eq;
      end
      for (int k = 2; k <= STAGES; k++) begin
        if (w_adv[k]) begin
          r_valid[k] <= r_valid[k-1];
          r_taken[k] <= r_taken[k-1];
          r_eq[k]    <= r_eq[k-1];
        end
      end
    end
  end

  assign out_valid = r_valid[STAGES];
  assign taken     = r_taken[STAGES];
  assign eq        = r_eq[STAGES];

endmodule

// File: tb/tb_branch_cmp_pipe.sv
// Directed bench: four pipeline configurations driven from shared stimulus.
module tb_branch_cmp_pipe;
  import branch_cmp_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;

  logic s1_in_ready, s1_out_valid, s1_taken, s1_eq;
  logic s2_in_ready, s2_out_valid, s2_taken, s2_eq;
  logic s3_in_ready, s3_out_valid, s3_taken, s3_eq;
  logic w8_in_ready, w8_out_valid, w8_taken, w8_eq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_cmp_pipe #(.WIDTH(32), .STAGES(1)) u_s1 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(s1_in_ready),
    .a(a), .b(b), .op(op), .flush(flush), .out_valid(s1_out_valid),
    .out_ready(out_ready), .taken(s1_taken), .eq(s1_eq)
  );

  branch_cmp_pipe #(.WIDTH(32), .STAGES(2)) u_s2 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(s2_in_ready),
    .a(a), .b(b), .op(op), .flush(flush), .out_valid(s2_out_valid),
    .out_ready(out_ready), .taken(s2_taken), .eq(s2_eq)
  );

  branch_cmp_pipe #(.WIDTH(32), .STAGES(3)) u_s3 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(s3_in_ready),
    .a(a), .b(b), .op(op), .flush(flush), .out_valid(s3_out_valid),
    .out_ready(out_ready), .taken(s3_taken), .eq(s3_eq)
  );

  branch_cmp_pipe #(.WIDTH(8), .STAGES(1)) u_w8 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(w8_in_ready),
    .a(a[7:0]), .b(b[7:0]), .op(op), .flush(flush), .out_valid(w8_out_valid),
    .out_ready(out_ready), .taken(w8_taken), .eq(w8_eq)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ta, input logic [31:0] tb,
                       input logic [2:0] top);
    in_valid = v;
    a        = ta;
    b        = tb;
    op       = top;
  endtask

  // Leaves the bench at a falling edge with resetn just released.
  task automatic do_reset(input logic chk);
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    if (chk) begin
      check("rst_s1_in_ready",  s1_in_ready,  1'b0);
      check("rst_s1_out_valid", s1_out_valid, 1'b0);
      check("rst_s1_taken",     s1_taken,     1'b0);
      check("rst_s1_eq",        s1_eq,        1'b0);
      check("rst_s3_out_valid", s3_out_valid, 1'b0);
      check("rst_w8_in_ready",  w8_in_ready,  1'b0);
    end
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Streams one beat into the 1-stage DUTs and checks its result a cycle later.
  task automatic run_vec(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                         input logic [2:0] top, input logic exp_s1, input logic exp_w8);
    drive(1'b1, ta, tb, top);
    @(negedge clk);
    check({tag, "_s1"}, s1_taken, exp_s1);
    check({tag, "_w8"}, w8_taken, exp_w8);
  endtask

  initial begin
    resetn = 1'b1;
    drive(1'b0, 32'h0, 32'h0, CMP_EQ);
    do_reset(1'b1);

    // Single-stage basics
    drive(1'b1, 32'h12345678, 32'h12345678, CMP_EQ);
    #1 check("s1_in_ready_first", s1_in_ready, 1'b1);
    @(negedge clk);
    check("s1_eq_valid", s1_out_valid, 1'b1);
    check("s1_eq_taken", s1_taken,     1'b1);
    check("s1_eq_raw",   s1_eq,        1'b1);
    drive(1'b1, 32'h12345678, 32'h12345678, CMP_NE);
    @(negedge clk);
    check("s1_ne_taken", s1_taken, 1'b0);
    check("s1_ne_raw",   s1_eq,    1'b1);

    run_vec("lt_neg1",  32'hFFFFFFFF, 32'h00000001, CMP_LT,  1'b1, 1'b1);
    run_vec("ltu_neg1", 32'hFFFFFFFF, 32'h00000001, CMP_LTU, 1'b0, 1'b0);
    run_vec("ltz_min",  32'h80000000, 32'h00000000, CMP_LTZ, 1'b1, 1'b0);
    run_vec("gez_min",  32'h80000000, 32'h00000000, CMP_GEZ, 1'b0, 1'b1);
    run_vec("lez_zero", 32'h00000000, 32'h00000000, CMP_LEZ, 1'b1, 1'b1);
    run_vec("gtz_zero", 32'h00000000, 32'h00000000, CMP_GTZ, 1'b0, 1'b0);
    run_vec("ltz_bign", 32'h7FFFFFFF, 32'h80000000, CMP_LTZ, 1'b0, 1'b1);
    run_vec("gtz_pos",  32'h00000005, 32'hFFFFFFFF, CMP_GTZ, 1'b1, 1'b1);
    // 8-bit width: 0x80 is negative there but positive at 32 bits
    run_vec("w8_lt",    32'h00000080, 32'h0000007F, CMP_LT,  1'b0, 1'b1);
    run_vec("w8_ltu",   32'h00000080, 32'h0000007F, CMP_LTU, 1'b0, 1'b0);
    run_vec("w8_lez",   32'h00000080, 32'h0000007F, CMP_LEZ, 1'b0, 1'b1);
    check("w8_eq_raw",   w8_eq,        1'b0);
    check("w8_valid",    w8_out_valid, 1'b1);

    drive(1'b0, 32'h0, 32'h0, CMP_EQ);
    @(negedge clk);
    check("s1_bubble_valid", s1_out_valid, 1'b0);

    // Two stages, consumer stalled: only two beats fit
    do_reset(1'b0);
    out_ready = 1'b0;
    drive(1'b1, 32'h1, 32'h1, CMP_EQ);
    #1 check("s2_acc0_ready", s2_in_ready, 1'b1);
    @(negedge clk);
    drive(1'b1, 32'h1, 32'h2, CMP_EQ);
    #1 check("s2_acc1_ready", s2_in_ready, 1'b1);
    @(negedge clk);
    drive(1'b1, 32'h3, 32'h3, CMP_NE);
    #1 check("s2_full_ready", s2_in_ready, 1'b0);
    check("s2_full_valid", s2_out_valid, 1'b1);
    @(negedge clk);
    check("s2_hold_ready", s2_in_ready,  1'b0);
    check("s2_hold_taken", s2_taken,     1'b1);
    check("s2_hold_eq",    s2_eq,        1'b1);
    out_ready = 1'b1;
    #1 check("s2_release_ready", s2_in_ready, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, CMP_EQ);
    check("s2_r1_valid", s2_out_valid, 1'b1);
    check("s2_r1_taken", s2_taken,     1'b0);
    check("s2_r1_eq",    s2_eq,        1'b0);
    @(negedge clk);
    check("s2_r2_valid", s2_out_valid, 1'b1);
    check("s2_r2_taken", s2_taken,     1'b0);
    check("s2_r2_eq",    s2_eq,        1'b1);
    @(negedge clk);
    check("s2_drained", s2_out_valid, 1'b0);

    // Three stages, flush with the pipe full
    do_reset(1'b0);
    drive(1'b1, 32'h1, 32'h1, CMP_EQ);
    @(negedge clk);
    drive(1'b1, 32'h1, 32'h2, CMP_EQ);
    @(negedge clk);
    drive(1'b1, 32'h3, 32'h3, CMP_NE);
    @(negedge clk);
    check("s3_full_valid", s3_out_valid, 1'b1);
    check("s3_full_taken", s3_taken,     1'b1);
    check("s3_stream_ready", s3_in_ready, 1'b1);
    flush = 1'b1;
    drive(1'b1, 32'h9, 32'h9, CMP_EQ);
    #1 check("s3_flush_ready", s3_in_ready, 1'b0);
    @(negedge clk);
    check("s3_post_flush_valid", s3_out_valid, 1'b0);
    flush = 1'b0;
    drive(1'b1, 32'h7, 32'h9, CMP_LTU);
    #1 check("s3_new_ready", s3_in_ready, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, CMP_EQ);
    check("s3_lat1_valid", s3_out_valid, 1'b0);
    @(negedge clk);
    check("s3_lat2_valid", s3_out_valid, 1'b0);
    @(negedge clk);
    check("s3_lat3_valid", s3_out_valid, 1'b1);
    check("s3_lat3_taken", s3_taken,     1'b1);
    check("s3_lat3_eq",    s3_eq,        1'b0);
    @(negedge clk);
    check("s3_no_stale", s3_out_valid, 1'b0);

    // Two stages, asynchronous reset mid-stream
    do_reset(1'b0);
    drive(1'b1, 32'h5, 32'h5, CMP_EQ);
    repeat (3) @(negedge clk);
    check("s2_stream_valid", s2_out_valid, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check("s2_async_valid", s2_out_valid, 1'b0);
    check("s2_async_ready", s2_in_ready,  1'b0);
    @(negedge clk);
    resetn = 1'b1;
    drive(1'b1, 32'h2, 32'h2, CMP_EQ);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, CMP_EQ);
    check("s2_after_rst_lat1", s2_out_valid, 1'b0);
    @(negedge clk);
    check("s2_after_rst_lat2", s2_out_valid, 1'b1);
    check("s2_after_rst_taken", s2_taken,    1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_cmp_pipe.md
BRANCH_CMP_PIPE -- requirements
Module: branch_cmp_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; legal range 8..64.
REQ-002 Parameter STAGES, default 1: number of result register stages, which equals the latency; legal range 1..4.
REQ-003 clk  input  1  Single clock; all state changes on the rising edge.
REQ-004 resetn  input  1  Reset, asynchronous and active-low.
REQ-005 in_valid  input  1  Operand beat present.
REQ-006 in_ready  output  1  Block accepts the beat this cycle.
REQ-007 a  input  WIDTH  Operand rs.
REQ-008 b  input  WIDTH  Operand rt.
REQ-009 op  input  3  Compare mode (encodings in REQ-013).
REQ-010 flush  input  1  Kill all in-flight results.
REQ-011 out_valid  output  1  Result present at the final stage.
REQ-012 out_ready  input  1  Consumer takes the result this cycle.
REQ-013 taken  output  1  Branch condition result for op:
- 0 EQ: a==b
- 1 NE: a!=b
- 2 LTZ: a<0
- 3 GEZ: a>=0
- 4 LEZ: a<=0
- 5 GTZ: a>0
- 6 LT: a<b, signed
- 7 LTU: a<b, unsigned
REQ-014 eq  output  1  Raw a==b, independent of op.

Function
REQ-015 The comparison is evaluated combinationally on the accepted a, b, op and captured into stage 1 together with a valid bit.
REQ-016 Each stage k>1 loads from stage k-1, so a result accepted in cycle t appears at the output in cycle t+STAGES if nothing stalls.
REQ-017 A stage advances when it is empty or when its successor advances; the final stage advances when out_ready=1.
REQ-018 in_ready = !flush && (stage 1 empty || stage 1 advances); a transfer happens only when in_valid && in_ready.
REQ-019 A bubble (no transfer) loads valid=0 into stage 1 when stage 1 advances.
REQ-020 A stalled stage holds its valid bit, taken and eq unchanged.
REQ-021 Results leave in acceptance order; none is dropped or duplicated while flush=0.
REQ-022 flush=1 clears every valid bit at the next edge; in the flush cycle in_ready=0 and no beat is accepted.
REQ-023 out_valid is 0 in the cycle after a flush.
REQ-024 With in_valid=1 and out_ready=1 held continuously, throughput is one result per cycle for any STAGES.
REQ-025 Signed modes sign-interpret bit WIDTH-1; LTZ, GEZ, LEZ and GTZ ignore b.
REQ-026 The pipeline holds at most STAGES results; when all stages are full and out_ready=0, in_ready=0.
REQ-027 taken and eq are don't-care when out_valid=0, but they shall be driven from registers, never directly from the combinational logic.

Reset
REQ-028 resetn=0 clears every valid bit immediately without waiting for clk, so out_valid=0.
REQ-029 During reset in_ready=0 and the taken and eq registers are 0.
REQ-030 Reset asserted mid-operation discards all in-flight results.
REQ-031 The first beat is accepted on the first rising edge after resetn rises.

Structure
REQ-032 The op encodings (CMP_EQ..CMP_LTU) shall be localparams in a shared package/header used by the decoder and this block.
REQ-033 The comparison shall be a purely combinational sub-module branch_cmp_core, with inputs a, b, op and outputs taken, eq.
REQ-034 The stage registers shall be a parametrised array indexed 1..STAGES.

Verification
REQ-035 STAGES=1: a=b=0x12345678, op=EQ → taken=1 and eq=1 one cycle later; same operands with op=NE → taken=0.
REQ-036 Signed versus unsigned:
- a=0xFFFFFFFF, b=1: op=LT → taken=1; op=LTU → taken=0.
- a=0x80000000: op=LTZ → 1, op=GEZ → 0.
- a=0: op=LEZ → 1, op=GTZ → 0.
REQ-037 STAGES=2 with out_ready=0: send 3 beats → exactly 2 accepted and in_ready=0 thereafter; raise out_ready → results emerge in order, then the third beat is accepted.
REQ-038 STAGES=3 streaming: assert flush with 3 results in flight → out_valid=0 next cycle, no stale result appears, and a new beat accepted after the flush emerges 3 cycles later.
REQ-039 Drop resetn asynchronously mid-stream with STAGES=2 → out_valid falls before the next clk edge; after resetn rises, the first new result has latency 2.
REQ-040 WIDTH=8: a=0x80, b=0x7F → op=LT taken=1, op=LTU taken=0, op=LEZ taken=1.
